// File: rtl/uproc_pkg.sv
// uproc_pkg: widths, NOP encoding, fetch states and ControlPC layout shared across the micro-processor.
package uproc_pkg;

    localparam int INS_W = 13;
    localparam int PC_W = 6;
    localparam int CPC_W = PC_W + 1;
    localparam logic [INS_W-1:0] NOP_INS = 13'h1F00;

    localparam int JMP_EN_BIT = 6;
    localparam int JMP_ADDR_MSB = 5;
    localparam int JMP_ADDR_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } fetch_state_t;

    function automatic logic [CPC_W-1:0] make_jump(input logic [PC_W-1:0] target);
        return {1'b1, target};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register, fetch FSM and NOP mux feeding the decoder from synchronous program memory.
module instruction_fetch_unit
    import uproc_pkg::*;
#(
    parameter int INS_W = uproc_pkg::INS_W,
    parameter int PC_W = uproc_pkg::PC_W,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Run,
    input  logic             Stall,
    input  logic [PC_W:0]    ControlPC,
    output logic [PC_W-1:0]  PM_Addr,
    output logic             PM_RE,
    input  logic [INS_W-1:0] PM_RData,
    output logic [INS_W-1:0] Ins,
    output logic             InsValid,
    output logic [PC_W-1:0]  InsPC
);

    fetch_state_t state_q, state_d;
    logic [PC_W-1:0] addr_q, addr_d, pc_q, pc_d;
    logic jump;
    logic [PC_W-1:0] next_addr;

    assign jump = ControlPC[PC_W];
    assign next_addr = addr_q + PC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q <= START_PC;
            pc_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            pc_q <= pc_d;
        end
    end

    // Stall freezes everything; a jump only counts while a real instruction is on Ins.
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        pc_d = pc_q;
        if (!Stall) begin
            case (state_q)
                IDLE: state_d = Run ? FILL : IDLE;
                FILL: begin
                    pc_d = addr_q;
                    addr_d = next_addr;
                    state_d = Run ? RUN : IDLE;
                end
                RUN: begin
                    if (jump) begin
                        addr_d = ControlPC[PC_W-1:0];
                        state_d = Run ? FILL : IDLE;
                    end else if (Run) begin
                        pc_d = addr_q;
                        addr_d = next_addr;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign InsValid = (state_q == RUN);
    assign PM_RE = ~Stall & (state_q != IDLE);
    assign PM_Addr = addr_q;
    assign InsPC = pc_q;
    assign Ins = InsValid ? PM_RData : INS_W'(NOP_INS);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vector table plus hand sequences against a behavioural program memory.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic [6:0]  control_pc = '0;
    logic [5:0]  pm_addr;
    logic        pm_re;
    logic [12:0] pm_rdata = '0;
    logic [12:0] ins;
    logic        ins_valid;
    logic [5:0]  ins_pc;

    logic [12:0] mem [64];

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        run;
        logic        stall;
        logic [6:0]  cpc;
        logic        v;
        logic [12:0] ins;
        logic [5:0]  pc;
        logic [5:0]  addr;
        logic        re;
    } vec_t;

    vec_t vt[$];

    instruction_fetch_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .Run(run),
        .Stall(stall),
        .ControlPC(control_pc),
        .PM_Addr(pm_addr),
        .PM_RE(pm_re),
        .PM_RData(pm_rdata),
        .Ins(ins),
        .InsValid(ins_valid),
        .InsPC(ins_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (pm_re) pm_rdata <= mem[pm_addr];

    task automatic cmp(input string name, input logic [12:0] got, input logic [12:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk(input string tag, input logic v, input logic [12:0] i, input logic [5:0] pc,
                       input logic [5:0] a, input logic re);
        cmp({tag, " InsValid"}, 13'(ins_valid), 13'(v));
        cmp({tag, " Ins"}, ins, i);
        cmp({tag, " InsPC"}, 13'(ins_pc), 13'(pc));
        cmp({tag, " PM_Addr"}, 13'(pm_addr), 13'(a));
        cmp({tag, " PM_RE"}, 13'(pm_re), 13'(re));
    endtask

    task automatic add(input logic r, input logic s, input logic [6:0] c, input logic v,
                       input logic [12:0] i, input logic [5:0] pc, input logic [5:0] a, input logic re);
        vec_t e;
        e.run = r; e.stall = s; e.cpc = c; e.v = v; e.ins = i; e.pc = pc; e.addr = a; e.re = re;
        vt.push_back(e);
    endtask

    task automatic apply(input string tag, input logic r, input logic s, input logic [6:0] c,
                         input logic v, input logic [12:0] i, input logic [5:0] pc,
                         input logic [5:0] a, input logic re);
        run = r;
        stall = s;
        control_pc = c;
        @(posedge clk);
        #1;
        chk(tag, v, i, pc, a, re);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 13'(k);
        // start, jump 3->40, jump to 8, stall at InsPC=10
        add(1, 0, 7'h00, 0, 13'h1F00, 0, 0, 1);
        add(1, 0, 7'h00, 1, 0, 0, 1, 1);
        add(1, 0, 7'h00, 1, 1, 1, 2, 1);
        add(1, 0, 7'h00, 1, 2, 2, 3, 1);
        add(1, 0, 7'h00, 1, 3, 3, 4, 1);
        add(1, 0, 7'h68, 0, 13'h1F00, 3, 40, 1);
        add(1, 0, 7'h00, 1, 40, 40, 41, 1);
        add(1, 0, 7'h00, 1, 41, 41, 42, 1);
        add(1, 0, 7'h48, 0, 13'h1F00, 41, 8, 1);
        add(1, 0, 7'h00, 1, 8, 8, 9, 1);
        add(1, 0, 7'h00, 1, 9, 9, 10, 1);
        add(1, 0, 7'h00, 1, 10, 10, 11, 1);
        add(1, 1, 7'h00, 1, 10, 10, 11, 0);
        add(1, 1, 7'h00, 1, 10, 10, 11, 0);
        add(1, 1, 7'h00, 1, 10, 10, 11, 0);
        add(1, 0, 7'h00, 1, 11, 11, 12, 1);

        #2;
        chk("reset", 0, 13'h1F00, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("idle", 0, 13'h1F00, 0, 0, 0);

        foreach (vt[n])
            apply($sformatf("vec%0d", n), vt[n].run, vt[n].stall, vt[n].cpc,
                  vt[n].v, vt[n].ins, vt[n].pc, vt[n].addr, vt[n].re);

        // wrap 63->0 and jump to 63
        apply("wrap j62", 1, 0, 7'h7E, 0, 13'h1F00, 11, 62, 1);
        apply("wrap 62", 1, 0, 7'h00, 1, 62, 62, 63, 1);
        apply("wrap 63", 1, 0, 7'h00, 1, 63, 63, 0, 1);
        apply("wrap 0", 1, 0, 7'h00, 1, 0, 0, 1, 1);
        apply("wrap 1", 1, 0, 7'h00, 1, 1, 1, 2, 1);
        apply("j63 bub", 1, 0, 7'h7F, 0, 13'h1F00, 1, 63, 1);
        apply("j63 63", 1, 0, 7'h00, 1, 63, 63, 0, 1);
        apply("j63 0", 1, 0, 7'h00, 1, 0, 0, 1, 1);

        // stop at InsPC=20, resume without loss
        apply("j18 bub", 1, 0, 7'h52, 0, 13'h1F00, 0, 18, 1);
        apply("run 18", 1, 0, 7'h00, 1, 18, 18, 19, 1);
        apply("run 19", 1, 0, 7'h00, 1, 19, 19, 20, 1);
        apply("run 20", 1, 0, 7'h00, 1, 20, 20, 21, 1);
        run = 1'b0;
        #1;
        chk("stop cyc", 1, 20, 20, 21, 1);
        @(posedge clk);
        #1;
        chk("stop idle", 0, 13'h1F00, 20, 21, 0);
        apply("idle hold", 0, 0, 7'h00, 0, 13'h1F00, 20, 21, 0);
        apply("resume bub", 1, 0, 7'h00, 0, 13'h1F00, 20, 21, 1);
        apply("resume 21", 1, 0, 7'h00, 1, 21, 21, 22, 1);

        // stall together with jump
        apply("sj hold1", 1, 1, 7'h72, 1, 21, 21, 22, 0);
        apply("sj hold2", 1, 1, 7'h72, 1, 21, 21, 22, 0);
        apply("sj take", 1, 0, 7'h72, 0, 13'h1F00, 21, 50, 1);
        apply("sj 50", 1, 0, 7'h00, 1, 50, 50, 51, 1);
        apply("pre rst", 1, 0, 7'h00, 1, 51, 51, 52, 1);

        // asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst", 0, 13'h1F00, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rst hold", 0, 13'h1F00, 0, 0, 0);
        rst_n = 1'b1;
        apply("restart bub", 1, 0, 7'h00, 0, 13'h1F00, 0, 0, 1);
        apply("restart 0", 1, 0, 7'h00, 1, 0, 0, 1, 1);
        apply("restart 1", 1, 0, 7'h00, 1, 1, 1, 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
